// File: rtl/jtbubl_colmix_pkg.sv
// rtl/jtbubl_colmix_pkg.sv - shared types and constants for the colour mixer
package jtbubl_colmix_pkg;

   typedef enum logic {
      FADE_IDLE = 1'b0,
      FADE_RAMP = 1'b1
   } fade_state_t;

   localparam int PIPE_DLY = 4;

endpackage

// File: rtl/jtbubl_colmix_fader.sv
// rtl/jtbubl_colmix_fader.sv - frame-stepped brightness ramp toward a CPU target
module jtbubl_colmix_fader
   import jtbubl_colmix_pkg::*;
#(
   parameter int CW          = 4,
   parameter int FADE_FRAMES = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_we,
   input  logic [CW:0] i_din,
   input  logic        i_lvbl,
   output logic [CW:0] o_bright,
   output logic        o_busy
);

   localparam int          FW   = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
   localparam logic [CW:0] FULL = (CW+1)'(1 << CW);
   localparam logic [FW-1:0] LAST = FW'(FADE_FRAMES - 1);

   fade_state_t   r_state, w_nxt_state;
   logic [CW:0]   r_bright, w_nxt_bright;
   logic [CW:0]   r_target, w_nxt_target;
   logic [FW-1:0] r_cnt, w_nxt_cnt;
   logic          r_lvbl_l;
   logic          w_fall;
   logic [CW:0]   w_din_sat;

   assign w_fall    = r_lvbl_l & ~i_lvbl;
   assign w_din_sat = (i_din > FULL) ? FULL : i_din;
   assign o_bright  = r_bright;
   assign o_busy    = (r_state == FADE_RAMP);

   // State register; reset returns straight to full brightness
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= FADE_IDLE;
         r_bright <= FULL;
         r_target <= FULL;
         r_cnt    <= '0;
         r_lvbl_l <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_bright <= w_nxt_bright;
         r_target <= w_nxt_target;
         r_cnt    <= w_nxt_cnt;
         r_lvbl_l <= i_lvbl;
      end
   end

   // Next state: a write takes the cycle (retarget keeps the frame count), otherwise step on frame edges
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_bright = r_bright;
      w_nxt_target = r_target;
      w_nxt_cnt    = r_cnt;
      if (i_we) begin
         w_nxt_target = w_din_sat;
         if (w_din_sat == r_bright) begin
            w_nxt_state = FADE_IDLE;
            w_nxt_cnt   = '0;
         end else begin
            w_nxt_state = FADE_RAMP;
         end
      end else if (r_state == FADE_RAMP && w_fall) begin
         if (r_cnt == LAST) begin
            w_nxt_cnt    = '0;
            w_nxt_bright = (r_target > r_bright) ? r_bright + 1'b1 : r_bright - 1'b1;
            if (w_nxt_bright == r_target) w_nxt_state = FADE_IDLE;
         end else begin
            w_nxt_cnt = r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/jtframe_dual_ram.sv
// rtl/jtframe_dual_ram.sv - two-port synchronous RAM, registered reads, read-before-write
module jtframe_dual_ram #(
   parameter int dw = 8,
   parameter int aw = 10
) (
   input  logic          clk,
   input  logic [dw-1:0] data0,
   input  logic [aw-1:0] addr0,
   input  logic          we0,
   output logic [dw-1:0] q0,
   input  logic [dw-1:0] data1,
   input  logic [aw-1:0] addr1,
   input  logic          we1,
   output logic [dw-1:0] q1
);

   logic [dw-1:0] mem [0:(1<<aw)-1];

   // Reads return the contents from before any write on the same edge
   always_ff @(posedge clk) begin
      q0 <= mem[addr0];
      q1 <= mem[addr1];
      if (we0) mem[addr0] <= data0;
      if (we1) mem[addr1] <= data1;
   end

endmodule

// File: rtl/jtbubl_colmix_fade.sv
// rtl/jtbubl_colmix_fade.sv - layer priority, palette lookup, brightness fade and blank delay
module jtbubl_colmix_fade
   import jtbubl_colmix_pkg::*;
#(
   parameter int LAYERS      = 2,
   parameter int AW          = 10,
   parameter int CW          = 4,
   parameter int TW          = 4,
   parameter int FADE_FRAMES = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_pxl_cen,
   input  logic                 i_lhbl,
   input  logic                 i_lvbl,
   output logic                 o_lhbl_dly,
   output logic                 o_lvbl_dly,
   input  logic [LAYERS*AW-1:0] i_lyr_pxl,
   input  logic                 i_pal_cs,
   input  logic                 i_fade_cs,
   input  logic                 i_cpu_rnw,
   input  logic [AW:0]          i_cpu_addr,
   input  logic [7:0]           i_cpu_dout,
   output logic [7:0]           o_pal_dout,
   output logic                 o_fade_busy,
   output logic [CW-1:0]        o_red,
   output logic [CW-1:0]        o_green,
   output logic [CW-1:0]        o_blue
);

   localparam int PW = 2*CW + 1;

   logic [AW-1:0]       w_pal_addr, r_pal_addr, w_vid_addr;
   logic [7:0]          w_vid_even, w_vid_odd, w_cpu_even, w_cpu_odd;
   logic [15:0]         w_vid_word;
   logic [3*CW-1:0]     r_pal_q, r_col;
   logic [PIPE_DLY-1:0] r_hb, r_vb;
   logic [CW-1:0]       r_red, r_green, r_blue;
   logic [CW:0]         w_bright;
   logic [PW-1:0]       w_prod_r, w_prod_g, w_prod_b;
   logic                w_pal_we, r_lane, r_rd_en;
   logic                w_unused;

   // Priority mux: walk from the last layer down so the lowest opaque index wins
   always_comb begin
      w_pal_addr = i_lyr_pxl[(LAYERS-1)*AW +: AW];
      for (int i = LAYERS-2; i >= 0; i--) begin
         if (i_lyr_pxl[i*AW +: TW] != {TW{1'b1}}) w_pal_addr = i_lyr_pxl[i*AW +: AW];
      end
   end

   // The RAM re-reads every clk; on a pixel tick it already looks up the address being latched
   assign w_vid_addr = i_pxl_cen ? w_pal_addr : r_pal_addr;
   assign w_pal_we   = i_pal_cs & ~i_cpu_rnw;
   assign w_vid_word = {w_vid_odd, w_vid_even};

   jtframe_dual_ram #(.dw(8), .aw(AW)) u_pal_even (
      .clk   (i_clk),
      .data0 (i_cpu_dout),
      .addr0 (i_cpu_addr[AW:1]),
      .we0   (w_pal_we & ~i_cpu_addr[0]),
      .q0    (w_cpu_even),
      .data1 (8'h00),
      .addr1 (w_vid_addr),
      .we1   (1'b0),
      .q1    (w_vid_even)
   );

   jtframe_dual_ram #(.dw(8), .aw(AW)) u_pal_odd (
      .clk   (i_clk),
      .data0 (i_cpu_dout),
      .addr0 (i_cpu_addr[AW:1]),
      .we0   (w_pal_we & i_cpu_addr[0]),
      .q0    (w_cpu_odd),
      .data1 (8'h00),
      .addr1 (w_vid_addr),
      .we1   (1'b0),
      .q1    (w_vid_odd)
   );

   jtbubl_colmix_fader #(.CW(CW), .FADE_FRAMES(FADE_FRAMES)) u_fader (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_we     (i_fade_cs & ~i_cpu_rnw),
      .i_din    (i_cpu_dout[CW:0]),
      .i_lvbl   (i_lvbl),
      .o_bright (w_bright),
      .o_busy   (o_fade_busy)
   );

   // CPU read lane select follows the RAM's one-clk read latency
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lane  <= 1'b0;
         r_rd_en <= 1'b0;
      end else begin
         r_lane  <= i_cpu_addr[0];
         r_rd_en <= 1'b1;
      end
   end

   assign o_pal_dout = r_rd_en ? (r_lane ? w_cpu_odd : w_cpu_even) : 8'h00;

   assign w_prod_r = PW'(r_col[3*CW-1 -: CW]) * PW'(w_bright);
   assign w_prod_g = PW'(r_col[2*CW-1 -: CW]) * PW'(w_bright);
   assign w_prod_b = PW'(r_col[CW-1:0])       * PW'(w_bright);

   // Video pipeline: address, palette data, colour, scaled and blanked RGB
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pal_addr <= '0;
         r_pal_q    <= '0;
         r_col      <= '0;
         r_hb       <= '0;
         r_vb       <= '0;
         r_red      <= '0;
         r_green    <= '0;
         r_blue     <= '0;
      end else if (i_pxl_cen) begin
         r_pal_addr <= w_pal_addr;
         r_pal_q    <= w_vid_word[15 -: 3*CW];
         r_col      <= r_pal_q;
         r_hb       <= {r_hb[PIPE_DLY-2:0], i_lhbl};
         r_vb       <= {r_vb[PIPE_DLY-2:0], i_lvbl};
         if (r_hb[PIPE_DLY-2] & r_vb[PIPE_DLY-2]) begin
            r_red   <= w_prod_r[2*CW-1:CW];
            r_green <= w_prod_g[2*CW-1:CW];
            r_blue  <= w_prod_b[2*CW-1:CW];
         end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
         end
      end
   end

   assign o_lhbl_dly = r_hb[PIPE_DLY-1];
   assign o_lvbl_dly = r_vb[PIPE_DLY-1];
   assign o_red      = r_red;
   assign o_green    = r_green;
   assign o_blue     = r_blue;

   assign w_unused = &{1'b0, i_cpu_dout[7:CW+1], w_vid_word,
                       w_prod_r[2*CW], w_prod_g[2*CW], w_prod_b[2*CW]};

endmodule

// File: tb/tb_jtbubl_colmix_fade.sv
// tb/tb_jtbubl_colmix_fade.sv - self-checking bench for the colour mixer
module tb_jtbubl_colmix_fade;

   localparam int LAYERS = 2;
   localparam int AW     = 10;
   localparam int CW     = 4;
   localparam int TW     = 4;
   localparam int FF     = 2;

   logic                 clk = 1'b0;
   logic                 rst, pxl_cen, lhbl, lvbl;
   logic [LAYERS*AW-1:0] lyr;
   logic                 pal_cs, fade_cs, cpu_rnw;
   logic [AW:0]          cpu_addr;
   logic [7:0]           cpu_dout;
   logic                 lhbl_dly, lvbl_dly, fade_busy;
   logic [7:0]           pal_dout;
   logic [CW-1:0]        red, green, blue;

   always #5 clk = ~clk;

   jtbubl_colmix_fade #(
      .LAYERS(LAYERS), .AW(AW), .CW(CW), .TW(TW), .FADE_FRAMES(FF)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_pxl_cen   (pxl_cen),
      .i_lhbl      (lhbl),
      .i_lvbl      (lvbl),
      .o_lhbl_dly  (lhbl_dly),
      .o_lvbl_dly  (lvbl_dly),
      .i_lyr_pxl   (lyr),
      .i_pal_cs    (pal_cs),
      .i_fade_cs   (fade_cs),
      .i_cpu_rnw   (cpu_rnw),
      .i_cpu_addr  (cpu_addr),
      .i_cpu_dout  (cpu_dout),
      .o_pal_dout  (pal_dout),
      .o_fade_busy (fade_busy),
      .o_red       (red),
      .o_green     (green),
      .o_blue      (blue)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  m_even [0:1023];
   logic [7:0]  m_odd  [0:1023];
   int          m_bright, m_tgt, m_cnt;
   bit          m_busy, m_lvbl_prev;
   logic [13:0] pq [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] colour_of(input logic [19:0] l);
      int          sel;
      logic [9:0]  code;
      logic [15:0] word;
      sel = LAYERS - 1;
      for (int i = LAYERS - 1; i >= 0; i--) begin
         code = l[i*AW +: AW];
         if ((code % 16) != 15) sel = i;
      end
      code = l[sel*AW +: AW];
      word = {m_odd[code], m_even[code]};
      return word[15:4];
   endfunction

   function automatic logic [11:0] scale(input logic [11:0] c, input int b);
      int r, g, bl;
      logic [31:0] rr, gg, bb;
      r  = int'(c[11:8]) * b / 16;
      g  = int'(c[7:4])  * b / 16;
      bl = int'(c[3:0])  * b / 16;
      rr = r; gg = g; bb = bl;
      return {rr[3:0], gg[3:0], bb[3:0]};
   endfunction

   // One clk: pixel model, palette model, fade model, then the edge and checks
   task automatic step();
      logic [13:0] ent, exp;
      bit          do_cmp;
      bit          fall;
      int          t;
      do_cmp = 0;
      exp    = '0;
      if (rst) begin
         pq.delete();
         m_bright = 16; m_tgt = 16; m_cnt = 0; m_busy = 0; m_lvbl_prev = 0;
      end else begin
         if (pxl_cen) begin
            pq.push_back({lhbl, lvbl, colour_of(lyr)});
            if (pq.size() == 4) begin
               ent = pq.pop_front();
               exp = {ent[13], ent[12], (ent[13] && ent[12]) ? scale(ent[11:0], m_bright) : 12'h000};
               do_cmp = 1;
            end
         end
         if (pal_cs && !cpu_rnw) begin
            if (cpu_addr[0]) m_odd[cpu_addr[10:1]]  = cpu_dout;
            else             m_even[cpu_addr[10:1]] = cpu_dout;
         end
         fall = m_lvbl_prev && !lvbl;
         m_lvbl_prev = lvbl;
         if (fade_cs && !cpu_rnw) begin
            t = int'(cpu_dout[4:0]);
            if (t > 16) t = 16;
            m_tgt = t;
            if (t == m_bright) begin
               m_busy = 0; m_cnt = 0;
            end else begin
               m_busy = 1;
            end
         end else if (m_busy && fall) begin
            m_cnt++;
            if (m_cnt == FF) begin
               m_cnt = 0;
               m_bright += (m_tgt > m_bright) ? 1 : -1;
               if (m_bright == m_tgt) m_busy = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      if (do_cmp) chk("pixel", 32'({lhbl_dly, lvbl_dly, red, green, blue}), 32'(exp));
      chk("busy", 32'(fade_busy), 32'(m_busy));
   endtask

   task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d, input bit fade);
      pal_cs = !fade; fade_cs = fade; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
      step();
      pal_cs = 1'b0; fade_cs = 1'b0; cpu_rnw = 1'b1;
   endtask

   task automatic cpu_rd(input logic [10:0] a, input logic [7:0] exp);
      pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
      step();
      chk("pal_rd", 32'(pal_dout), 32'(exp));
      pal_cs = 1'b0;
   endtask

   task automatic frame();
      lvbl = 1'b0;
      repeat (3) step();
      lvbl = 1'b1;
      repeat (6) step();
   endtask

   initial begin
      logic [31:0] r;
      logic [9:0]  wa;
      logic [10:0] ra;
      rst = 1'b1; pxl_cen = 1'b1; lhbl = 1'b1; lvbl = 1'b1; lyr = '0;
      pal_cs = 1'b0; fade_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_dout = '0;
      repeat (3) step();
      chk("rst_rgb", 32'({red, green, blue}), 32'h0);
      chk("rst_dly", 32'({lhbl_dly, lvbl_dly}), 32'h0);
      chk("rst_pal", 32'(pal_dout), 32'h0);
      rst = 1'b0;

      // Fill the palette with random bytes while video is stalled
      pxl_cen = 1'b0;
      for (int w = 0; w < 1024; w++) begin
         r  = $urandom;
         wa = 10'(w);
         cpu_wr({wa, 1'b0}, r[7:0], 0);
         cpu_wr({wa, 1'b1}, r[15:8], 0);
      end
      cpu_wr(11'h246, 8'h12, 0);
      cpu_wr(11'h247, 8'hAB, 0);
      cpu_rd(11'h247, 8'hAB);
      cpu_rd(11'h246, 8'h12);
      for (int k = 0; k < 8; k++) begin
         r  = $urandom;
         ra = r[10:0];
         cpu_rd(ra, ra[0] ? m_odd[ra[10:1]] : m_even[ra[10:1]]);
      end
      cpu_wr(11'h08A, 8'h78, 0);
      cpu_wr(11'h08B, 8'h56, 0);
      cpu_wr(11'h140, 8'h40, 0);
      cpu_wr(11'h141, 8'hF8, 0);
      cpu_wr(11'h400, 8'h30, 0);
      cpu_wr(11'h401, 8'h12, 0);

      // Priority: transparent layer 0 falls through to layer 1
      pxl_cen = 1'b1;
      lyr = {10'h123, 10'h05F};
      step();
      lyr = {10'h123, 10'h045};
      repeat (3) step();
      chk("prio_l1", 32'({red, green, blue}), 32'hAB1);
      step();
      chk("prio_l0", 32'({red, green, blue}), 32'h567);

      // Random pixels, transparency, blanking and pixel-enable gaps
      for (int k = 0; k < 400; k++) begin
         r = $urandom;
         pxl_cen = (r[1:0] != 2'b00);
         lhbl    = (r[4:2] != 3'b000);
         lvbl    = (r[8:5] != 4'b0000);
         r = $urandom;
         lyr = r[19:0];
         if (r[21:20] == 2'b00) lyr[3:0] = 4'hF;
         if (r[23:22] == 2'b00) lyr[AW+3:AW] = 4'hF;
         step();
      end

      // Horizontal blank shows up exactly four ticks later
      pxl_cen = 1'b1; lhbl = 1'b1; lvbl = 1'b1;
      lyr = {10'h123, 10'h0A0};
      repeat (4) step();
      lhbl = 1'b0;
      step();
      lhbl = 1'b1;
      repeat (2) step();
      chk("hb_before", 32'({lhbl_dly, red, green, blue}), 32'h1F84);
      step();
      chk("hb_at4", 32'({lhbl_dly, red, green, blue}), 32'h0000);
      step();
      chk("hb_after", 32'({lhbl_dly, red, green, blue}), 32'h1F84);

      // Collision: write and video read of word 0x200 on the same edge
      lyr = {10'h123, 10'h200};
      pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 11'h401; cpu_dout = 8'h9C;
      step();
      pal_cs = 1'b0; cpu_rnw = 1'b1;
      repeat (3) step();
      chk("coll_old", 32'({red, green, blue}), 32'h123);
      step();
      chk("coll_new", 32'({red, green, blue}), 32'h9C3);

      // Fade down to black
      lyr = {10'h123, 10'h0A0};
      cpu_wr(11'h000, 8'h00, 1);
      chk("fade_start", 32'(fade_busy), 32'h1);
      repeat (2) frame();
      chk("fade_15", 32'({red, green, blue}), 32'hE73);
      repeat (14) frame();
      chk("fade_8", 32'({red, green, blue}), 32'h742);
      repeat (15) frame();
      chk("fade_1_busy", 32'(fade_busy), 32'h1);
      frame();
      chk("fade_0_busy", 32'(fade_busy), 32'h0);
      chk("fade_0_rgb", 32'({red, green, blue}), 32'h000);

      // Retarget mid-ramp keeps the frame count; oversize target clamps
      cpu_wr(11'h000, 8'h06, 1);
      repeat (9) frame();
      cpu_wr(11'h000, 8'h00, 1);
      frame();
      chk("rev_down_3", 32'({red, green, blue}), 32'h210);
      frame();
      cpu_wr(11'h000, 8'h1F, 1);
      frame();
      chk("rev_up_4", 32'({red, green, blue}), 32'h321);
      repeat (24) frame();
      chk("sat_16_rgb", 32'({red, green, blue}), 32'hF84);
      chk("sat_16_busy", 32'(fade_busy), 32'h0);

      // Writing the current brightness forces idle
      cpu_wr(11'h000, 8'h00, 1);
      frame();
      cpu_wr(11'h000, 8'h10, 1);
      chk("eq_idle", 32'(fade_busy), 32'h0);
      frame();
      chk("eq_rgb", 32'({red, green, blue}), 32'hF84);

      // Reset mid-ramp
      cpu_wr(11'h000, 8'h00, 1);
      repeat (3) frame();
      rst = 1'b1;
      repeat (2) step();
      chk("rst_mid_rgb", 32'({red, green, blue}), 32'h000);
      chk("rst_mid_busy", 32'(fade_busy), 32'h0);
      rst = 1'b0;
      repeat (2) frame();
      chk("rst_mid_full", 32'({red, green, blue}), 32'hF84);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
